alu_share_arbiter: RTL

- Shares the single-cycle ALU datapath between two requesters, for example an integer pipeline and a branch/compare unit.
- Each requester has a valid/ready request channel. Results return on one response channel tagged with the requester id.
- The block registers operands, drives the ALU for exactly one cycle, then registers the result and the zero flag.
- Round-robin arbitration and a 3-state FSM sequence each operation.

---
 rtl/alu_share_arbiter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
// Two-requester front end for a shared single-cycle ALU: round-robin grant,
// one-cycle operand issue, registered result returned on a tagged response channel.
module alu_share_arbiter #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CTLW  = 4,
   parameter int unsigned CNTW  = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             req0_valid_i,
   output logic             req0_ready_o,
   input  logic [CTLW-1:0]  req0_ctl_i,
   input  logic [WIDTH-1:0] req0_a_i,
   input  logic [WIDTH-1:0] req0_b_i,
   input  logic             req1_valid_i,
   output logic             req1_ready_o,
   input  logic [CTLW-1:0]  req1_ctl_i,
   input  logic [WIDTH-1:0] req1_a_i,
   input  logic [WIDTH-1:0] req1_b_i,
   output logic             rsp_valid_o,
   input  logic             rsp_ready_i,
   output logic             rsp_id_o,
   output logic [WIDTH-1:0] rsp_result_o,
   output logic             rsp_zero_o,
   output logic [CTLW-1:0]  alu_ctl_o,
   output logic [WIDTH-1:0] alu_a_o,
   output logic [WIDTH-1:0] alu_b_o,
   input  logic [WIDTH-1:0] alu_out_i,
   input  logic             alu_zero_i,
   output logic [CNTW-1:0]  op_count_o
);

   typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

   state_e           state_q, state_d;
   logic [CTLW-1:0]  op_ctl_q, op_ctl_d;
   logic [WIDTH-1:0] op_a_q, op_a_d;
   logic [WIDTH-1:0] op_b_q, op_b_d;
   logic             rsp_id_q, rsp_id_d;
   logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
   logic             rsp_zero_q, rsp_zero_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [CNTW-1:0]  op_count_q, op_count_d;
   logic             last_grant_q, last_grant_d;

   logic grant_valid;
   logic grant_id;
   logic accept;
   logic rsp_done;

   // Round-robin: on a tie the requester that did not win last time goes first.
   always_comb begin
      grant_valid = 1'b0;
      grant_id    = 1'b0;
      unique case ({req1_valid_i, req0_valid_i})
         2'b01: begin
            grant_valid = 1'b1;
            grant_id    = 1'b0;
         end
         2'b10: begin
            grant_valid = 1'b1;
            grant_id    = 1'b1;
         end
         2'b11: begin
            grant_valid = 1'b1;
            grant_id    = ~last_grant_q;
         end
         default: begin
            grant_valid = 1'b0;
            grant_id    = 1'b0;
         end
      endcase
   end

   assign accept   = (state_q == StIdle) && grant_valid;
   assign rsp_done = (state_q == StResp) && rsp_valid_q && rsp_ready_i;

   // FSM state register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (accept) state_d = StExec;
         StExec:  state_d = StResp;
         StResp:  if (rsp_done) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // FSM outputs
   always_comb begin
      req0_ready_o = 1'b0;
      req1_ready_o = 1'b0;
      if (state_q == StIdle && grant_valid) begin
         req0_ready_o = ~grant_id;
         req1_ready_o = grant_id;
      end
   end

   always_comb begin
      op_ctl_d     = op_ctl_q;
      op_a_d       = op_a_q;
      op_b_d       = op_b_q;
      rsp_id_d     = rsp_id_q;
      rsp_result_d = rsp_result_q;
      rsp_zero_d   = rsp_zero_q;
      rsp_valid_d  = rsp_valid_q;
      op_count_d   = op_count_q;
      last_grant_d = last_grant_q;
      if (accept) begin
         op_ctl_d     = grant_id ? req1_ctl_i : req0_ctl_i;
         op_a_d       = grant_id ? req1_a_i   : req0_a_i;
         op_b_d       = grant_id ? req1_b_i   : req0_b_i;
         rsp_id_d     = grant_id;
         last_grant_d = grant_id;
      end
      if (state_q == StExec) begin
         rsp_result_d = alu_out_i;
         rsp_zero_d   = alu_zero_i;
         rsp_valid_d  = 1'b1;
      end
      if (rsp_done) begin
         rsp_valid_d = 1'b0;
         op_count_d  = op_count_q + CNTW'(1);
      end
   end

   // Pointer resets to 1 so requester 0 wins the first tie.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         op_ctl_q     <= '0;
         op_a_q       <= '0;
         op_b_q       <= '0;
         rsp_id_q     <= 1'b0;
         rsp_result_q <= '0;
         rsp_zero_q   <= 1'b0;
         rsp_valid_q  <= 1'b0;
         op_count_q   <= '0;
         last_grant_q <= 1'b1;
      end else begin
         op_ctl_q     <= op_ctl_d;
         op_a_q       <= op_a_d;
         op_b_q       <= op_b_d;
         rsp_id_q     <= rsp_id_d;
         rsp_result_q <= rsp_result_d;
         rsp_zero_q   <= rsp_zero_d;
         rsp_valid_q  <= rsp_valid_d;
         op_count_q   <= op_count_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign alu_ctl_o    = op_ctl_q;
   assign alu_a_o      = op_a_q;
   assign alu_b_o      = op_b_q;
   assign rsp_valid_o  = rsp_valid_q;
   assign rsp_id_o     = rsp_id_q;
   assign rsp_result_o = rsp_result_q;
   assign rsp_zero_o   = rsp_zero_q;
   assign op_count_o   = op_count_q;

endmodule
